// File: rtl/avst_pkt_sanitizer_pkg.sv
// Shared types and helpers for the Avalon-ST packet sanitizer.
package avst_pkt_sanitizer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IN_PKT = 2'd1,
        TERM   = 2'd2,
        DROP   = 2'd3
    } state_t;

    // Symbols per beat for the default 512-bit bus.
    localparam int BEAT_BYTES = 64;

    // Wide enough to hold MAX_PKT_BYTES plus one extra full beat without wrapping.
    function automatic int byte_cnt_width(input int max_pkt_bytes, input int beat_bytes);
        return $clog2(max_pkt_bytes + beat_bytes) + 1;
    endfunction

    // Increment that sticks at the all-ones value of a 'width'-bit counter (width <= 64).
    function automatic logic [63:0] sat_inc(input logic [63:0] value, input int width);
        logic [63:0] max_val;
        max_val = {64{1'b1}} >> (64 - width);
        return (value >= max_val) ? max_val : value + 64'd1;
    endfunction

endpackage

// File: rtl/avst_sanitizer_sat_cnt.sv
// Saturating event counter with synchronous clear; clear wins over enable.
module avst_sanitizer_sat_cnt
    import avst_pkt_sanitizer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    // Count events, holding at all-ones once full.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= WIDTH'(sat_inc(64'(count), WIDTH));
        end
    end

endmodule

// File: rtl/avst_pkt_sanitizer.sv
// Avalon-ST framing sanitizer: drops orphan beats, closes packets that lose
// their EOP with a synthetic error beat, truncates oversize packets.
module avst_pkt_sanitizer
    import avst_pkt_sanitizer_pkg::*;
#(
    parameter int DATA_WIDTH    = 8 * BEAT_BYTES,
    parameter int EMPTY_WIDTH   = 6,
    parameter int MAX_PKT_BYTES = 9600,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   in_ready,
    input  logic                   in_valid,
    input  logic                   in_startofpacket,
    input  logic                   in_endofpacket,
    input  logic [EMPTY_WIDTH-1:0] in_empty,
    input  logic                   in_error,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic                   out_startofpacket,
    output logic                   out_endofpacket,
    output logic [EMPTY_WIDTH-1:0] out_empty,
    output logic                   out_error,
    output logic [DATA_WIDTH-1:0]  out_data,
    input  logic                   stat_clear,
    output logic [CNT_WIDTH-1:0]   stat_pkt_cnt,
    output logic [CNT_WIDTH-1:0]   stat_err_cnt,
    output logic [CNT_WIDTH-1:0]   stat_drop_cnt
);

    localparam int BYTES_PER_BEAT = DATA_WIDTH / 8;
    localparam int BC_W           = byte_cnt_width(MAX_PKT_BYTES, BYTES_PER_BEAT);

    state_t          state, state_nxt;
    logic [BC_W-1:0] byte_cnt, byte_cnt_nxt, beat_len, byte_sum;
    logic            load_ok, accept, hold_sop;
    logic            fwd, synth, force_err, drop_inc, err_inc, pkt_inc;

    // Output register may take a new beat when empty or being drained.
    assign load_ok  = !out_valid || out_ready;
    // A SOP arriving mid-packet (or while dropping) is held off until the FSM is back in IDLE.
    assign hold_sop = in_valid && in_startofpacket && (state == IN_PKT || state == DROP);
    assign in_ready = !reset && (state != TERM) && !hold_sop && load_ok;
    assign accept   = in_valid && in_ready;

    assign beat_len = in_endofpacket ? BC_W'(BYTES_PER_BEAT) - BC_W'(in_empty)
                                     : BC_W'(BYTES_PER_BEAT);
    assign byte_sum = byte_cnt + beat_len;
    assign pkt_inc  = out_valid && out_ready && out_endofpacket;

    // Framing state and running packet length.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            byte_cnt <= '0;
        end else begin
            state    <= state_nxt;
            byte_cnt <= byte_cnt_nxt;
        end
    end

    // Next-state decode plus forward/synthesise/count strobes.
    always_comb begin
        state_nxt    = state;
        byte_cnt_nxt = byte_cnt;
        fwd          = 1'b0;
        synth        = 1'b0;
        force_err    = 1'b0;
        drop_inc     = 1'b0;
        err_inc      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (in_startofpacket) begin
                        fwd = 1'b1;
                        if (!in_endofpacket) begin
                            state_nxt    = IN_PKT;
                            byte_cnt_nxt = BC_W'(BYTES_PER_BEAT);
                        end
                    end else begin
                        drop_inc = 1'b1;
                    end
                end
            end
            IN_PKT: begin
                if (in_valid && in_startofpacket) begin
                    state_nxt = TERM;
                end else if (accept) begin
                    fwd          = 1'b1;
                    byte_cnt_nxt = byte_sum;
                    if (byte_sum > BC_W'(MAX_PKT_BYTES)) begin
                        force_err = 1'b1;
                        err_inc   = 1'b1;
                        state_nxt = in_endofpacket ? IDLE : DROP;
                    end else if (in_endofpacket) begin
                        state_nxt = IDLE;
                    end
                end
            end
            TERM: begin
                if (load_ok) begin
                    synth     = 1'b1;
                    err_inc   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            DROP: begin
                if (in_valid && in_startofpacket) begin
                    state_nxt = IDLE;
                end else if (accept) begin
                    drop_inc = 1'b1;
                    if (in_endofpacket) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Single output register stage; payload frozen while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid         <= 1'b0;
            out_startofpacket <= 1'b0;
            out_endofpacket   <= 1'b0;
            out_error         <= 1'b0;
            out_empty         <= '0;
            out_data          <= '0;
        end else if (load_ok) begin
            out_valid <= fwd || synth;
            if (synth) begin
                out_startofpacket <= 1'b0;
                out_endofpacket   <= 1'b1;
                out_error         <= 1'b1;
                out_empty         <= '1;
                out_data          <= '0;
            end else if (fwd) begin
                out_startofpacket <= in_startofpacket;
                out_endofpacket   <= in_endofpacket || force_err;
                out_error         <= in_error || force_err;
                out_empty         <= in_empty;
                out_data          <= in_data;
            end
        end
    end

    avst_sanitizer_sat_cnt #(.WIDTH(CNT_WIDTH)) u_pkt_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (stat_clear),
        .enable (pkt_inc),
        .count  (stat_pkt_cnt)
    );

    avst_sanitizer_sat_cnt #(.WIDTH(CNT_WIDTH)) u_err_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (stat_clear),
        .enable (err_inc),
        .count  (stat_err_cnt)
    );

    avst_sanitizer_sat_cnt #(.WIDTH(CNT_WIDTH)) u_drop_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (stat_clear),
        .enable (drop_inc),
        .count  (stat_drop_cnt)
    );

endmodule

// File: tb/tb_avst_pkt_sanitizer.sv
// Bench for avst_pkt_sanitizer: table vectors, directed framing sequences and
// a randomized stream compared against a packet-level reference model.
module tb_avst_pkt_sanitizer;

    localparam int DW   = 512;
    localparam int EW   = 6;
    localparam int MAXB = 256;
    localparam int CW   = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_ready, in_valid, in_startofpacket, in_endofpacket, in_error;
    logic [EW-1:0] in_empty;
    logic [DW-1:0] in_data;
    logic          out_ready, out_valid, out_startofpacket, out_endofpacket, out_error;
    logic [EW-1:0] out_empty;
    logic [DW-1:0] out_data;
    logic          stat_clear;
    logic [CW-1:0] stat_pkt_cnt, stat_err_cnt, stat_drop_cnt;

    avst_pkt_sanitizer #(
        .DATA_WIDTH(DW), .EMPTY_WIDTH(EW), .MAX_PKT_BYTES(MAXB), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .in_ready(in_ready), .in_valid(in_valid), .in_startofpacket(in_startofpacket),
        .in_endofpacket(in_endofpacket), .in_empty(in_empty), .in_error(in_error),
        .in_data(in_data),
        .out_ready(out_ready), .out_valid(out_valid), .out_startofpacket(out_startofpacket),
        .out_endofpacket(out_endofpacket), .out_empty(out_empty), .out_error(out_error),
        .out_data(out_data),
        .stat_clear(stat_clear), .stat_pkt_cnt(stat_pkt_cnt), .stat_err_cnt(stat_err_cnt),
        .stat_drop_cnt(stat_drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          sop;
        logic          eop;
        logic          err;
        logic [EW-1:0] empty;
        logic [DW-1:0] data;
    } beat_t;

    typedef struct {
        logic          sop, eop, err;
        logic [EW-1:0] empty;
        logic [7:0]    fill;
        logic          exp_valid, exp_sop, exp_eop, exp_err;
        logic [EW-1:0] exp_empty;
        logic [7:0]    exp_fill;
    } vec_t;

    beat_t in_q[$];
    beat_t exp_q[$];
    int    errors = 0;
    int    checks = 0;
    int    exp_pkt, exp_err, exp_drop;
    bit    rand_ready = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic chk_data(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got=%h want=%h", name, got, want);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic beat_t mk(input logic sop, input logic eop, input logic err,
                                 input logic [EW-1:0] empty);
        beat_t b;
        b.sop = sop; b.eop = eop; b.err = err; b.empty = empty; b.data = rand_data();
        return b;
    endfunction

    task automatic add_pkt(input int nbeats, input logic [EW-1:0] last_empty);
        for (int i = 0; i < nbeats; i++)
            in_q.push_back(mk(i == 0, i == nbeats - 1, 1'b0, (i == nbeats - 1) ? last_empty : '0));
    endtask

    // Reference model: walks the offered beat list packet by packet and lists
    // every beat that should leave the block, independent of backpressure.
    task automatic build_expected();
        bit    in_pkt = 1'b0;
        bit    dropping = 1'b0;
        int    bytes = 0;
        beat_t b, s;
        s.sop = 1'b0; s.eop = 1'b1; s.err = 1'b1; s.empty = '1; s.data = '0;
        exp_q.delete();
        exp_pkt = 0; exp_err = 0; exp_drop = 0;
        foreach (in_q[i]) begin
            b = in_q[i];
            if (dropping) begin
                if (!b.sop) begin
                    exp_drop++;
                    if (b.eop) dropping = 1'b0;
                    continue;
                end
                dropping = 1'b0;
            end
            if (in_pkt) begin
                if (b.sop) begin
                    exp_q.push_back(s);
                    exp_err++;
                    in_pkt = 1'b0;
                end else begin
                    bytes += b.eop ? 64 - int'(b.empty) : 64;
                    if (bytes > MAXB) begin
                        b.eop = 1'b1; b.err = 1'b1;
                        exp_q.push_back(b);
                        exp_err++;
                        in_pkt   = 1'b0;
                        dropping = !in_q[i].eop;
                    end else begin
                        exp_q.push_back(b);
                        if (b.eop) in_pkt = 1'b0;
                    end
                    continue;
                end
            end
            if (b.sop) begin
                exp_q.push_back(b);
                if (!b.eop) begin in_pkt = 1'b1; bytes = 64; end
            end else begin
                exp_drop++;
            end
        end
        foreach (exp_q[i]) if (exp_q[i].eop) exp_pkt++;
    endtask

    task automatic drive(input beat_t b);
        in_valid = 1'b1; in_startofpacket = b.sop; in_endofpacket = b.eop;
        in_error = b.err; in_empty = b.empty; in_data = b.data;
    endtask

    task automatic check_beat(input beat_t w);
        chk("beat_ctrl", 64'({out_startofpacket, out_endofpacket, out_error, out_empty}),
            64'({w.sop, w.eop, w.err, w.empty}));
        chk_data("beat_data", out_data, w.data);
    endtask

    task automatic clear_stats();
        @(negedge clk);
        in_valid = 1'b0; stat_clear = 1'b1;
        @(negedge clk);
        stat_clear = 1'b0;
    endtask

    // Offers in_q in order, checks each delivered beat and stall behaviour, then counters.
    task automatic run_seq();
        int            idx = 0;
        int            cyc = 0;
        int            limit;
        bit            held = 1'b0;
        logic [EW+2:0] held_ctrl;
        logic [DW-1:0] held_data;
        limit = 40 * in_q.size() + 200;
        build_expected();
        while ((idx < in_q.size() || exp_q.size() != 0) && cyc < limit) begin
            @(negedge clk);
            cyc++;
            out_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (idx < in_q.size()) drive(in_q[idx]);
            else in_valid = 1'b0;
            #1;
            if (held) begin
                chk("stall_valid", 64'(out_valid), 64'(1));
                chk("stall_ctrl", 64'({out_startofpacket, out_endofpacket, out_error, out_empty}),
                    64'(held_ctrl));
                chk_data("stall_data", out_data, held_data);
            end
            held = 1'b0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("extra_beat", 64'(1), 64'(0));
                else check_beat(exp_q.pop_front());
            end else if (out_valid) begin
                chk("in_ready_stalled", 64'(in_ready), 64'(0));
                held      = 1'b1;
                held_ctrl = {out_startofpacket, out_endofpacket, out_error, out_empty};
                held_data = out_data;
            end
            if (in_valid && in_ready) idx++;
        end
        if (idx < in_q.size() || exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL seq_timeout: offered %0d of %0d, %0d beats still expected",
                     idx, in_q.size(), exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        chk("pkt_cnt", 64'(stat_pkt_cnt), 64'(exp_pkt));
        chk("err_cnt", 64'(stat_err_cnt), 64'(exp_err));
        chk("drop_cnt", 64'(stat_drop_cnt), 64'(exp_drop));
        in_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vec_t vecs[8];
        int   want_pkt, want_drop;
        beat_t b;

        reset = 1'b1; in_valid = 1'b0; in_startofpacket = 1'b0; in_endofpacket = 1'b0;
        in_error = 1'b0; in_empty = '0; in_data = '0; out_ready = 1'b1; stat_clear = 1'b0;

        // {sop,eop,err,empty,fill, exp_valid,exp_sop,exp_eop,exp_err,exp_empty,exp_fill}
        vecs[0] = '{1, 1, 0, 6'd10, 8'hA5, 1, 1, 1, 0, 6'd10, 8'hA5};
        vecs[1] = '{0, 0, 0, 6'd0,  8'h11, 0, 0, 0, 0, 6'd0,  8'h00};
        vecs[2] = '{1, 1, 1, 6'd0,  8'h3C, 1, 1, 1, 1, 6'd0,  8'h3C};
        vecs[3] = '{0, 1, 1, 6'd7,  8'h22, 0, 0, 0, 0, 6'd0,  8'h00};
        vecs[4] = '{1, 1, 0, 6'd63, 8'hFF, 1, 1, 1, 0, 6'd63, 8'hFF};
        vecs[5] = '{0, 0, 0, 6'd0,  8'h33, 0, 0, 0, 0, 6'd0,  8'h00};
        vecs[6] = '{1, 1, 0, 6'd5,  8'h00, 1, 1, 1, 0, 6'd5,  8'h00};
        vecs[7] = '{0, 1, 0, 6'd2,  8'h44, 0, 0, 0, 0, 6'd0,  8'h00};

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("ready_in_reset", 64'(in_ready), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_ctrl", 64'({out_startofpacket, out_endofpacket, out_error, out_empty}), 64'(0));
        chk_data("rst_out_data", out_data, '0);
        chk("rst_cnts", 64'({stat_pkt_cnt, stat_err_cnt}) | 64'(stat_drop_cnt), 64'(0));
        chk("ready_after_reset", 64'(in_ready), 64'(1));

        // Single-beat table from IDLE: forwarded with 1-cycle latency or dropped
        want_pkt = 0; want_drop = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_startofpacket = vecs[i].sop; in_endofpacket = vecs[i].eop;
            in_error = vecs[i].err; in_empty = vecs[i].empty; in_data = {64{vecs[i].fill}};
            @(posedge clk);
            #1;
            chk("tbl_valid", 64'(out_valid), 64'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                want_pkt++;
                chk("tbl_ctrl", 64'({out_startofpacket, out_endofpacket, out_error, out_empty}),
                    64'({vecs[i].exp_sop, vecs[i].exp_eop, vecs[i].exp_err, vecs[i].exp_empty}));
                chk_data("tbl_data", out_data, {64{vecs[i].exp_fill}});
            end else begin
                want_drop++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("tbl_pkt_cnt", 64'(stat_pkt_cnt), 64'(want_pkt));
        chk("tbl_drop_cnt", 64'(stat_drop_cnt), 64'(want_drop));
        chk("tbl_err_cnt", 64'(stat_err_cnt), 64'(0));

        // Back-to-back 3-beat packets
        clear_stats();
        #1;
        chk("clear_all", 64'({stat_pkt_cnt, stat_err_cnt}) | 64'(stat_drop_cnt), 64'(0));
        for (int p = 0; p < 4; p++) add_pkt(3, 6'd4);
        run_seq();
        chk("b2b_pkt_const", 64'(stat_pkt_cnt), 64'(4));

        // Orphan beat then a valid packet
        clear_stats();
        in_q.push_back(mk(1'b0, 1'b0, 1'b0, 6'd0));
        add_pkt(3, 6'd4);
        run_seq();
        chk("orphan_drop_const", 64'(stat_drop_cnt), 64'(1));

        // Lost EOP: SOP, data, then a new SOP
        clear_stats();
        in_q.push_back(mk(1'b1, 1'b0, 1'b0, 6'd0));
        in_q.push_back(mk(1'b0, 1'b0, 1'b0, 6'd0));
        add_pkt(2, 6'd9);
        run_seq();
        chk("term_err_const", 64'(stat_err_cnt), 64'(1));

        // Oversize: 6 beats with a 256-byte limit
        clear_stats();
        add_pkt(6, 6'd0);
        run_seq();
        chk("trunc_err_const", 64'(stat_err_cnt), 64'(1));
        chk("trunc_drop_const", 64'(stat_drop_cnt), 64'(1));

        // Randomized framing with random backpressure
        clear_stats();
        for (int i = 0; i < 400; i++) begin
            b = mk($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                   $urandom_range(0, 7) == 0, 6'd0);
            if (b.eop) b.empty = 6'($urandom_range(0, 63));
            in_q.push_back(b);
        end
        rand_ready = 1'b1;
        run_seq();
        rand_ready = 1'b0;

        // Reset mid-packet, then a fresh packet
        @(negedge clk);
        out_ready = 1'b1;
        drive(mk(1'b1, 1'b0, 1'b0, 6'd0));
        @(negedge clk);
        drive(mk(1'b0, 1'b0, 1'b0, 6'd0));
        @(negedge clk);
        in_valid = 1'b0; reset = 1'b1;
        #1;
        chk("midrst_ready", 64'(in_ready), 64'(0));
        @(posedge clk);
        #1;
        chk("midrst_valid", 64'(out_valid), 64'(0));
        chk("midrst_ctrl", 64'({out_startofpacket, out_endofpacket, out_error, out_empty}), 64'(0));
        chk_data("midrst_data", out_data, '0);
        chk("midrst_cnts", 64'({stat_pkt_cnt, stat_err_cnt}) | 64'(stat_drop_cnt), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        add_pkt(2, 6'd3);
        run_seq();

        // stat_clear coincident with a drop increment
        clear_stats();
        drive(mk(1'b0, 1'b0, 1'b0, 6'd0));
        @(posedge clk);
        #1;
        chk("drop_before_clear", 64'(stat_drop_cnt), 64'(1));
        @(negedge clk);
        drive(mk(1'b0, 1'b0, 1'b0, 6'd0));
        stat_clear = 1'b1;
        @(posedge clk);
        #1;
        chk("clear_beats_inc", 64'(stat_drop_cnt), 64'(0));
        @(negedge clk);
        in_valid = 1'b0; stat_clear = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
